serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 1..32.
REQ-002 Clk  input  1  system clock; all state changes on rising edge.
REQ-003 Rst  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
REQ-004 Start  input  1  request to begin one addition; sampled on rising edge.
REQ-005 A  input  WIDTH  first operand, captured at accepted Start.
REQ-006 B  input  WIDTH  second operand, captured at accepted Start.
REQ-007 Cin  input  1  carry-in for add mode, captured at accepted Start.
REQ-008 Sub  input  1  mode, captured at accepted Start; 0 = A+B+Cin, 1 = A-B.
REQ-009 Busy  output  1  high while an operation is in progress.
REQ-010 Done  output  1  single-cycle pulse; results valid.
REQ-011 S  output  WIDTH  sum/difference result.
REQ-012 Cout  output  1  carry out of MSB (add); not-borrow (sub).
REQ-013 Ovf  output  1  two's-complement overflow flag.

Function
REQ-014 Block SHALL compute with exactly one 1-bit full-adder cell plus a carry register, one bit per clock, LSB first.
REQ-015 FSM SHALL have states IDLE, RUN, DONE; IDLE->RUN on Start=1; RUN->DONE after WIDTH bit cycles; DONE->RUN on Start=1, else DONE->IDLE.
REQ-016 Start SHALL be accepted only in IDLE or DONE; Start in RUN SHALL be ignored with no effect on the in-flight operation.
REQ-017 At accepting edge k: A, B, mode and initial carry captured; bit counter cleared; state RUN.
REQ-018 Initial carry SHALL be Cin when Sub=0, and 1 when Sub=1 (Cin ignored); B SHALL be bitwise inverted when Sub=1.
REQ-019 Edges k+1..k+WIDTH SHALL process bits 0..WIDTH-1; at edge k+WIDTH state becomes DONE and S, Cout, Ovf are loaded.
REQ-020 Done SHALL be 1 exactly in the cycle following edge k+WIDTH (latency WIDTH clocks from acceptance) and 0 otherwise.
REQ-021 Busy SHALL be 1 in RUN only; 0 in IDLE and DONE.
REQ-022 S, Cout, Ovf SHALL hold their last loaded values until the next DONE entry; intermediate bits SHALL never appear on S.
REQ-023 Ovf SHALL equal carry into MSB XOR carry out of MSB; for WIDTH=1 the same rule applies to bit 0.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH; Cout SHALL be bit WIDTH of the full-precision result.
REQ-025 Start asserted in the DONE cycle SHALL begin the next operation with no idle gap (back-to-back throughput WIDTH+1 clocks).
REQ-026 Operand input changes after the accepting edge SHALL not affect the result.

Reset
REQ-027 Rst=1 at a rising edge SHALL force state IDLE, Busy=0, Done=0, S=0, Cout=0, Ovf=0, carry and counter cleared.
REQ-028 Rst SHALL take priority over Start; Rst during RUN SHALL abort the operation with no Done pulse.
REQ-029 Start in the first cycle after Rst deasserts SHALL be accepted normally.

Verification (WIDTH=8 unless stated)
REQ-030 A=0x00 B=0x00 Cin=0 Sub=0 -> Done 8 clocks after acceptance, S=0x00 Cout=0 Ovf=0; Busy high 8 cycles.
REQ-031 A=0xFF B=0x01 Cin=0 -> S=0x00 Cout=1 Ovf=0; A=0x7F B=0x01 Cin=0 -> S=0x80 Cout=0 Ovf=1; A=0xFF B=0x00 Cin=1 -> S=0x00 Cout=1 Ovf=0.
REQ-032 Sub=1: A=0x05 B=0x07 -> S=0xFE Cout=0 Ovf=0; A=0x80 B=0x01 -> S=0x7F Cout=1 Ovf=1.
REQ-033 Start pulsed again at clock 3 of RUN with different operands -> ignored; first result unchanged and Done at clock 8; then Start held in DONE cycle -> second result Done 9 clocks after first Done.
REQ-034 Rst asserted at clock 4 of RUN -> Busy=0, Done never pulses, S=0 Cout=0 Ovf=0 next cycle; following Start completes correctly.
REQ-035 WIDTH=1: all 8 combinations of A, B, Cin with Sub=0 -> S/Cout match full-adder truth table (e.g. 1+1+1 -> S=1 Cout=1), Done 1 clock after acceptance.

Source files
------------

// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder: the requester drives start and operands,
// the adder returns status and results.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, s, cout, ovf
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, s, cout, ovf
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop, LSB first,
// WIDTH clocks per operation; results are loaded only on entry to DONE.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] s_q;
    logic             carry;
    logic             cout_q;
    logic             ovf_q;
    logic [CW-1:0]    cnt;

    logic             sum_bit;
    logic             carry_nxt;
    logic [WIDTH-1:0] acc_nxt;
    logic             accept;

    // The single full-adder cell.
    assign sum_bit   = a_sh[0] ^ b_sh[0] ^ carry;
    assign carry_nxt = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    assign acc_nxt = (acc >> 1) | (WIDTH'(sum_bit) << (WIDTH - 1));

    assign accept = bus.start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            s_q    <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            // Subtraction is A + ~B + 1.
            state <= RUN;
            a_sh  <= bus.a;
            b_sh  <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub ? 1'b1 : bus.cin;
            acc   <= '0;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            acc   <= acc_nxt;
            carry <= carry_nxt;
            cnt   <= cnt + 1'b1;
            if (cnt == LAST) begin
                // carry still holds the carry into the MSB on this edge.
                state  <= DONE;
                s_q    <= acc_nxt;
                cout_q <= carry_nxt;
                ovf_q  <= carry ^ carry_nxt;
            end
        end else begin
            state <= IDLE;
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.s    = s_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 arithmetic, handshake, reset abort,
// and a WIDTH=1 instance walked through the full-adder truth table.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) b8 ();
    serial_adder_if #(.WIDTH(1)) b1 ();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
    serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for done (bounded), counting clocks since acceptance and busy cycles.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!b8.done && lat < 20) begin
            if (b8.busy) bcnt++;
            tick();
            lat++;
        end
    endtask

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic sub,
                       input logic [7:0] es, input logic ec, input logic eo);
        int lat, bcnt;
        b8.start = 1'b1; b8.a = a; b8.b = b; b8.cin = cin; b8.sub = sub;
        tick();
        // Scramble operands after acceptance; result must not change.
        b8.start = 1'b0;
        b8.a = 8'($urandom); b8.b = 8'($urandom);
        b8.cin = 1'($urandom); b8.sub = 1'($urandom);
        wait_done(lat, bcnt);
        chk({tag, ".lat"},  lat, 8);
        chk({tag, ".busy"}, bcnt, 8);
        chk({tag, ".s"},    b8.s, es);
        chk({tag, ".cout"}, b8.cout, ec);
        chk({tag, ".ovf"},  b8.ovf, eo);
        chk({tag, ".busy_at_done"}, b8.busy, 0);
    endtask

    // {cout, ovf, s} for WIDTH=1 indexed by {a, b, cin}; ovf = cin ^ cout.
    logic [2:0] fa_tbl [8] = '{3'b000, 3'b011, 3'b001, 3'b100,
                               3'b001, 3'b100, 3'b110, 3'b101};

    initial begin
        int lat, bcnt;
        b8.start = 1'b1; b8.a = 8'hAA; b8.b = 8'h55; b8.cin = 1'b1; b8.sub = 1'b0;
        b1.start = 1'b0; b1.a = 1'b0;  b1.b = 1'b0;  b1.cin = 1'b0; b1.sub = 1'b0;

        // Reset held with start asserted: reset wins.
        tick(); tick();
        chk("rst.busy", b8.busy, 0);
        chk("rst.done", b8.done, 0);
        chk("rst.s",    b8.s, 0);
        chk("rst.cout", b8.cout, 0);
        chk("rst.ovf",  b8.ovf, 0);
        rst = 1'b0;
        b8.start = 1'b0;

        // First op issued in the first cycle after reset release.
        op8("zero",   8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1 & 1'b0, 1'b0);
        tick();
        chk("idle_after_done.done", b8.done, 0);
        chk("idle_after_done.busy", b8.busy, 0);
        op8("ff+01",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        op8("7f+01",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        op8("ff+00c", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        op8("3c+45c", 8'h3C, 8'h45, 1'b1, 1'b0, 8'h82, 1'b0, 1'b1);
        op8("05-07",  8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        op8("80-01",  8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        tick(); tick();
        chk("hold.s",    b8.s, 8'h7F);
        chk("hold.cout", b8.cout, 1);
        chk("hold.ovf",  b8.ovf, 1);

        // Start during RUN ignored; then back-to-back start in the DONE cycle.
        b8.start = 1'b1; b8.a = 8'h12; b8.b = 8'h34; b8.cin = 1'b0; b8.sub = 1'b0;
        tick();
        b8.start = 1'b0;
        tick(); tick(); tick();
        b8.start = 1'b1; b8.a = 8'hFF; b8.b = 8'hFF; b8.cin = 1'b1; b8.sub = 1'b1;
        tick();
        b8.start = 1'b0;
        lat = 4; bcnt = 0;
        while (!b8.done && lat < 20) begin tick(); lat++; end
        chk("ign.lat",  lat, 8);
        chk("ign.s",    b8.s, 8'h46);
        chk("ign.cout", b8.cout, 0);
        chk("ign.ovf",  b8.ovf, 0);
        b8.start = 1'b1; b8.a = 8'h80; b8.b = 8'h80; b8.cin = 1'b0; b8.sub = 1'b0;
        tick();
        b8.start = 1'b0;
        chk("b2b.busy", b8.busy, 1);
        chk("b2b.s_held", b8.s, 8'h46);
        wait_done(lat, bcnt);
        chk("b2b.gap",  lat + 1, 9);
        chk("b2b.s",    b8.s, 8'h00);
        chk("b2b.cout", b8.cout, 1);
        chk("b2b.ovf",  b8.ovf, 1);
        tick();

        // Reset at clock 4 of RUN aborts with no done pulse.
        op8("pre", 8'h3C, 8'h45, 1'b1, 1'b0, 8'h82, 1'b0, 1'b1);
        b8.start = 1'b1; b8.a = 8'h11; b8.b = 8'h22; b8.cin = 1'b0; b8.sub = 1'b0;
        tick();
        b8.start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort.busy", b8.busy, 0);
        chk("abort.done", b8.done, 0);
        chk("abort.s",    b8.s, 0);
        chk("abort.cout", b8.cout, 0);
        chk("abort.ovf",  b8.ovf, 0);
        bcnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (b8.done) bcnt++;
            tick();
        end
        chk("abort.no_done", bcnt, 0);
        op8("post", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);

        // WIDTH=1: full-adder truth table with one-clock latency.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            b1.start = 1'b1; b1.a = v[2]; b1.b = v[1]; b1.cin = v[0]; b1.sub = 1'b0;
            tick();
            b1.start = 1'b0;
            chk($sformatf("w1.%0d.busy", i), b1.busy, 1);
            tick();
            chk($sformatf("w1.%0d.done", i), b1.done, 1);
            chk($sformatf("w1.%0d.res", i), {b1.cout, b1.ovf, b1.s}, fa_tbl[i]);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
